// File: rtl/lite_copy_master.sv
// AHB-lite word copy initiator: one non-overlapped read then write per word.
// Addresses wrap modulo 2^32; misaligned or zero-length commands finish at once.
module lite_copy_master #(
    parameter int LEN_W   = 14,
    parameter bit FIX_SRC = 1'b0
) (
    input  logic             pll_core_cpuclk,
    input  logic             pad_cpu_rst_b,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_src_addr,
    input  logic [31:0]      cfg_dst_addr,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             dma_busy,
    output logic             dma_done,
    output logic             dma_err,
    output logic             lite_mmc_hsel,
    output logic [31:0]      lite_yy_haddr,
    output logic [2:0]       lite_yy_hsize,
    output logic [1:0]       lite_yy_htrans,
    output logic             lite_yy_hwrite,
    output logic [31:0]      lite_yy_hwdata,
    input  logic [31:0]      mmc_lite_hrdata,
    input  logic             mmc_lite_hready,
    input  logic [1:0]       mmc_lite_hresp
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_D = 3'd2;
    localparam logic [2:0] S_WR_A = 3'd3;
    localparam logic [2:0] S_WR_D = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic             err_q, err_d;
    logic             misaligned;
    logic             resp_err;

    assign misaligned = (cfg_src_addr[1:0] != 2'b00) || (cfg_dst_addr[1:0] != 2'b00);
    assign resp_err   = (mmc_lite_hresp != 2'b00);

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    src_d = cfg_src_addr;
                    dst_d = cfg_dst_addr;
                    cnt_d = cfg_len;
                    err_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cfg_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_RD_A: state_d = S_RD_D;
            S_RD_D: begin
                if (mmc_lite_hready) begin
                    data_d = mmc_lite_hrdata;
                    if (resp_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WR_A;
                    end
                end
            end
            S_WR_A: state_d = S_WR_D;
            S_WR_D: begin
                if (mmc_lite_hready) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    dst_d = dst_q + 32'd4;
                    if (!FIX_SRC) begin
                        src_d = src_q + 32'd4;
                    end
                    if (resp_err) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cnt_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD_A;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode from state so an async reset idles the bus at once.
    always_comb begin
        dma_busy       = (state_q != S_IDLE);
        dma_done       = (state_q == S_DONE);
        dma_err        = err_q;
        lite_mmc_hsel  = (state_q == S_RD_A) || (state_q == S_WR_A);
        lite_yy_htrans = lite_mmc_hsel ? 2'b10 : 2'b00;
        lite_yy_hwrite = (state_q == S_WR_A);
        lite_yy_hsize  = 3'b010;
        lite_yy_haddr  = 32'h0;
        if (state_q == S_RD_A) begin
            lite_yy_haddr = src_q;
        end else if (state_q == S_WR_A) begin
            lite_yy_haddr = dst_q;
        end
        lite_yy_hwdata = (state_q == S_WR_D) ? data_q : 32'h0;
    end

endmodule

// File: tb/tb_lite_copy_master.sv
// Bench for lite_copy_master: SRAM slave with stalls/errors plus a
// word-level copy model predicting memory, bus trace, latency and flags.
module tb_lite_copy_master;

    localparam int LEN_W = 14;
    localparam int MW    = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_start = 1'b0;
    logic [31:0]      cfg_src_addr = '0;
    logic [31:0]      cfg_dst_addr = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             dma_busy, dma_done, dma_err;
    logic             lite_mmc_hsel;
    logic [31:0]      lite_yy_haddr, lite_yy_hwdata;
    logic [2:0]       lite_yy_hsize;
    logic [1:0]       lite_yy_htrans;
    logic             lite_yy_hwrite;
    logic [31:0]      mmc_lite_hrdata = '0;
    logic             mmc_lite_hready = 1'b1;
    logic [1:0]       mmc_lite_hresp = 2'b00;

    always #5 clk = ~clk;

    lite_copy_master #(.LEN_W(LEN_W), .FIX_SRC(1'b0)) dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst_b   (rst_n),
        .cfg_start       (cfg_start),
        .cfg_src_addr    (cfg_src_addr),
        .cfg_dst_addr    (cfg_dst_addr),
        .cfg_len         (cfg_len),
        .dma_busy        (dma_busy),
        .dma_done        (dma_done),
        .dma_err         (dma_err),
        .lite_mmc_hsel   (lite_mmc_hsel),
        .lite_yy_haddr   (lite_yy_haddr),
        .lite_yy_hsize   (lite_yy_hsize),
        .lite_yy_htrans  (lite_yy_htrans),
        .lite_yy_hwrite  (lite_yy_hwrite),
        .lite_yy_hwdata  (lite_yy_hwdata),
        .mmc_lite_hrdata (mmc_lite_hrdata),
        .mmc_lite_hready (mmc_lite_hready),
        .mmc_lite_hresp  (mmc_lite_hresp)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem     [MW];
    logic [31:0] exp_mem [MW];
    logic [32:0] trace_q[$];
    logic [32:0] exp_q[$];

    logic        dp_valid = 1'b0;
    logic        dp_write = 1'b0;
    logic [31:0] dp_addr = '0;
    logic [31:0] last_wr = '0;
    logic        last_wr_v = 1'b0;
    int          stall_left = 0;
    int          stall_max = 0;
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    int          err_rd = -1;
    int          hsel_cnt = 0;
    int          proto_bad = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'(MW - 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM slave: tracks the data phase, stalls reads of the last written word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_valid   = 1'b0;
            stall_left = 0;
        end else begin
            if (dp_valid) begin
                if (!mmc_lite_hready) begin
                    stall_left--;
                    stall_cnt++;
                end else begin
                    if (dp_write) begin
                        mem[widx(dp_addr)] = lite_yy_hwdata;
                        last_wr   = dp_addr;
                        last_wr_v = 1'b1;
                    end else begin
                        rd_cnt++;
                    end
                    dp_valid = 1'b0;
                end
            end
            if (lite_mmc_hsel) begin
                hsel_cnt++;
                if (lite_yy_htrans !== 2'b10 || lite_yy_hsize !== 3'b010 || dp_valid)
                    proto_bad++;
                trace_q.push_back({lite_yy_hwrite, lite_yy_haddr});
                dp_valid   = 1'b1;
                dp_write   = lite_yy_hwrite;
                dp_addr    = lite_yy_haddr;
                stall_left = (!lite_yy_hwrite && last_wr_v && lite_yy_haddr == last_wr) ? 1 : 0;
                if (stall_max > 0)
                    stall_left += int'($urandom_range(0, stall_max));
            end else if (lite_yy_htrans !== 2'b00) begin
                proto_bad++;
            end
        end
    end

    always @(negedge clk) begin
        mmc_lite_hready = !(dp_valid && stall_left > 0);
        mmc_lite_hrdata = (dp_valid && !dp_write) ? mem[widx(dp_addr)] : $urandom;
        mmc_lite_hresp  = (dp_valid && !dp_write && mmc_lite_hready && rd_cnt == err_rd)
                          ? 2'b01 : 2'b00;
    end

    task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input int err_r, input int smax, input string tag);
        logic        mis;
        logic        exp_err;
        logic        erred;
        logic [31:0] sa, da;
        int          full, cyc, exp_cyc, bad, n;
        stall_max = smax;
        err_rd    = err_r;
        rd_cnt    = 0;
        stall_cnt = 0;
        hsel_cnt  = 0;
        proto_bad = 0;
        trace_q.delete();
        exp_q.delete();
        for (int i = 0; i < MW; i++) exp_mem[i] = mem[i];
        mis     = (src[1:0] != 2'b00) || (dst[1:0] != 2'b00);
        exp_err = mis;
        erred   = 1'b0;
        full    = 0;
        if (!mis) begin
            for (int i = 0; i < len; i++) begin
                sa = src + 32'(i) * 32'd4;
                da = dst + 32'(i) * 32'd4;
                exp_q.push_back({1'b0, sa});
                if (i == err_r) begin
                    erred   = 1'b1;
                    exp_err = 1'b1;
                    break;
                end
                exp_q.push_back({1'b1, da});
                exp_mem[widx(da)] = exp_mem[widx(sa)];
                full++;
            end
        end
        @(negedge clk);
        cfg_src_addr = src;
        cfg_dst_addr = dst;
        cfg_len      = LEN_W'(len);
        cfg_start    = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        cyc = 1;
        chk({tag, "_busy1"}, 64'(dma_busy), 64'(1));
        chk({tag, "_err1"}, 64'(dma_err), 64'(mis));
        while (!dma_done && cyc < 600) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(dma_done), 64'(1));
        exp_cyc = 1 + 4 * full + (erred ? 2 : 0) + stall_cnt;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_err"}, 64'(dma_err), 64'(exp_err));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(dma_done), 64'(0));
        chk({tag, "_idle"}, 64'(dma_busy), 64'(0));
        chk({tag, "_err_sticky"}, 64'(dma_err), 64'(exp_err));
        chk({tag, "_hsel_cnt"}, 64'(hsel_cnt), 64'(exp_q.size()));
        chk({tag, "_proto"}, 64'(proto_bad), 64'(0));
        bad = 0;
        n = (trace_q.size() < exp_q.size()) ? trace_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (trace_q[i] !== exp_q[i]) bad++;
        chk({tag, "_trace"}, 64'(bad), 64'(0));
        bad = 0;
        for (int i = 0; i < MW; i++) if (mem[i] !== exp_mem[i]) bad++;
        chk({tag, "_mem"}, 64'(bad), 64'(0));
    endtask

    initial begin
        logic [31:0] rs, rd;
        int          rl, re;
        for (int i = 0; i < MW; i++) mem[i] = $urandom;
        mem[0] = 32'h11;
        mem[1] = 32'h22;
        mem[2] = 32'h33;
        mem[3] = 32'h44;
        mem[widx(32'h100)] = 32'hA5;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(dma_busy), 64'(0));
        chk("rst_done", 64'(dma_done), 64'(0));
        chk("rst_err", 64'(dma_err), 64'(0));
        chk("rst_hsel", 64'(lite_mmc_hsel), 64'(0));
        chk("rst_haddr", 64'(lite_yy_haddr), 64'(0));
        chk("rst_htrans", 64'(lite_yy_htrans), 64'(0));
        chk("rst_hwrite", 64'(lite_yy_hwrite), 64'(0));
        chk("rst_hwdata", 64'(lite_yy_hwdata), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_cmd(32'h0, 32'h100, 4, -1, 0, "copy4");
        chk("copy4_w0", 64'(mem[widx(32'h100)]), 64'h11);
        chk("copy4_w3", 64'(mem[widx(32'h10C)]), 64'h44);

        run_cmd(32'h40, 32'h80, 0, -1, 0, "len0");
        run_cmd(32'h2, 32'h200, 3, -1, 0, "missrc");
        run_cmd(32'h0, 32'h201, 3, -1, 0, "misdst");
        run_cmd(32'h10, 32'h280, 2, -1, 0, "clrerr");

        mem[widx(32'h100)] = 32'hA5;
        run_cmd(32'h100, 32'h104, 3, -1, 0, "overlap");
        chk("overlap_w3", 64'(mem[widx(32'h10C)]), 64'hA5);

        run_cmd(32'h200, 32'h300, 5, 1, 0, "rderr");
        run_cmd(32'h400, 32'hFFFF_FFF8, 3, -1, 1, "wrap");

        for (int k = 0; k < 8; k++) begin
            rs = 32'($urandom) & 32'hFFFF_FFFC;
            rd = 32'($urandom) & 32'hFFFF_FFFC;
            rl = int'($urandom_range(1, 8));
            re = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rl - 1)) : -1;
            run_cmd(rs, rd, rl, re, int'($urandom_range(0, 2)), $sformatf("rnd%0d", k));
        end

        err_rd    = -1;
        stall_max = 2;
        @(negedge clk);
        cfg_src_addr = 32'h500;
        cfg_dst_addr = 32'h600;
        cfg_len      = LEN_W'(4);
        cfg_start    = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (dp_valid && dp_write) break;
            @(posedge clk);
            #1;
        end
        chk("mid_wrd_seen", 64'(dp_valid && dp_write), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(dma_busy), 64'(0));
        chk("mid_done", 64'(dma_done), 64'(0));
        chk("mid_err", 64'(dma_err), 64'(0));
        chk("mid_hsel", 64'(lite_mmc_hsel), 64'(0));
        chk("mid_haddr", 64'(lite_yy_haddr), 64'(0));
        chk("mid_htrans", 64'(lite_yy_htrans), 64'(0));
        chk("mid_hwrite", 64'(lite_yy_hwrite), 64'(0));
        chk("mid_hwdata", 64'(lite_yy_hwdata), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_cmd(32'h700, 32'h800, 3, -1, 0, "postrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
